imm_encoder: RTL and testbench

- Streaming immediate encoder: the inverse of Sign_Extend. Takes a 32-bit immediate value, an immediate type (same Imm_src encoding) and a base instruction word. Emits the instruction with the immediate packed into the correct bit fields.
- Sits in the program loader / self-test path, in front of instruction memory writes. Checks range and alignment, and counts encoded words and errors.
- 2-stage pipeline with valid/ready on both sides.

---
 rtl/imm_encoder.sv | 83 ++++++++
 tb/tb_imm_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage streaming encoder that packs an immediate into an instruction word.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     input handshake for {imm_src, imm, base}
//   imm_src, imm, base    immediate type, immediate value, base instruction
//   out_valid/out_ready   output handshake for {out_ins, out_err}
//   out_ins, out_err      encoded instruction and "not encodable" flag
//   enc_count, err_count  wrapping counts of drained words and drained errors
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_src,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ins,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [2:0] IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm, s1_base;
    logic        adv, err, sx11, sx12, sx20;
    logic [31:0] mask, field;
    assign adv      = !out_valid | out_ready;
    assign in_ready = !s1_valid | adv;
    // Unrecognised type codes fall through to I-type in every ternary chain.
    always_comb begin
        sx11  = &s1_imm[31:11] | ~|s1_imm[31:11];
        sx12  = &s1_imm[31:12] | ~|s1_imm[31:12];
        sx20  = &s1_imm[31:20] | ~|s1_imm[31:20];
        mask  = (s1_src == IMM_S || s1_src == IMM_B) ? 32'hFE00_0F80 :
                (s1_src == IMM_U || s1_src == IMM_J) ? 32'hFFFF_F000 : 32'hFFF0_0000;
        field = (s1_src == IMM_S) ? {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0} :
                (s1_src == IMM_B) ? {s1_imm[12], s1_imm[10:5], 13'b0, s1_imm[4:1], s1_imm[11], 7'b0} :
                (s1_src == IMM_U) ? {s1_imm[31:12], 12'b0} :
                (s1_src == IMM_J) ? {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'b0} :
                                    {s1_imm[11:0], 20'b0};
        err   = (s1_src == IMM_B) ? (s1_imm[0] | !sx12) :
                (s1_src == IMM_U) ? (|s1_imm[11:0]) :
                (s1_src == IMM_J) ? (s1_imm[0] | !sx20) : !sx11;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_src    <= '0;
            s1_imm    <= '0;
            s1_base   <= '0;
            out_valid <= 1'b0;
            out_ins   <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_src  <= imm_src;
                    s1_imm  <= imm;
                    s1_base <= base;
                end
            end
            if (adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ins <= (s1_base & ~mask) | (err ? 32'h0 : field);
                    out_err <= err;
                end
            end
            if (out_valid & out_ready) begin
                enc_count <= enc_count + CNT_W'(1);
                err_count <= err_count + CNT_W'(out_err);
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed stimulus with a decode-based reference model for imm_encoder.
module tb_imm_encoder;
    localparam int CNT_W = 4;
    localparam logic [2:0] TI = 3'd0, TS = 3'd1, TB = 3'd2, TU = 3'd3, TJ = 3'd4;
    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]       imm_src;
    logic [31:0]      imm, base, out_ins;
    logic [CNT_W-1:0] enc_count, err_count;
    int               total = 0, bad = 0, cyc = 0;
    typedef struct {
        logic [2:0]  s;
        logic [31:0] i, b, lit;
        logic        le;
        bit          hl, cl;
        int          acc;
    } ent_t;
    ent_t        q[$];
    ent_t        ce;
    bit          hold = 0;
    logic [31:0] hold_ins;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .out_ins(out_ins), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Reference decoder: what a Sign_Extend unit recovers from an instruction.
    function automatic logic [31:0] m_dec(input logic [2:0] s, input logic [31:0] x);
        case (s)
            TS:      return {{20{x[31]}}, x[31:25], x[11:7]};
            TB:      return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            TU:      return {x[31:12], 12'b0};
            TJ:      return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return {{20{x[31]}}, x[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] m_mask(input logic [2:0] s);
        case (s)
            TS, TB:  return 32'hFE00_0F80;
            TU, TJ:  return 32'hFFFF_F000;
            default: return 32'hFFF0_0000;
        endcase
    endfunction

    // Encodability as a numeric range / alignment question.
    function automatic logic m_err(input logic [2:0] s, input logic [31:0] i);
        longint v = longint'($signed(i));
        case (s)
            TB:      return (v % 2 != 0) || v < -4096 || v > 4095;
            TU:      return (i % 32'd4096) != 0;
            TJ:      return (v % 2 != 0) || v < -(64'sd1 << 20) || v > (64'sd1 << 20) - 1;
            default: return v < -2048 || v > 2047;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) hold = 0;
        else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_ins", out_ins, hold_ins);
            end
            hold     = out_valid && !out_ready;
            hold_ins = out_ins;
            if (out_valid && out_ready) begin
                chk("unexpected_out", q.size() != 0, 1);
                if (q.size() != 0) begin
                    ce = q.pop_front();
                    chk("err", out_err, m_err(ce.s, ce.i));
                    if (m_err(ce.s, ce.i)) chk("err_ins", out_ins, ce.b & ~m_mask(ce.s));
                    else begin
                        chk("decode", m_dec(ce.s, out_ins), ce.i);
                        chk("keep", out_ins & ~m_mask(ce.s), ce.b & ~m_mask(ce.s));
                    end
                    if (ce.hl) begin
                        chk("lit_ins", out_ins, ce.lit);
                        chk("lit_err", out_err, ce.le);
                    end
                    if (ce.cl) chk("latency", cyc - ce.acc, 2);
                end
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                        input logic [31:0] lit, input logic le, input bit hl, input bit cl);
        bit   ok = 0;
        ent_t e;
        in_valid = 1; imm_src = s; imm = i; base = b;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.s = s; e.i = i; e.b = b; e.lit = lit; e.le = le; e.hl = hl; e.cl = cl; e.acc = cyc;
                q.push_back(e);
                ok = 1;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
        chk("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; imm_src = 0; imm = 0; base = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ins", out_ins, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_enc", enc_count, 0);
        chk("rst_errc", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        send(TI, 32'd12,        32'h0000_0093, 32'h00C0_0093, 0, 1, 1);
        send(TI, 32'h7FF,       32'h0000_0093, 32'h7FF0_0093, 0, 1, 1);
        send(TS, 32'hFFFF_FFFC, 32'h0081_2023, 32'hFE81_2E23, 0, 1, 1);
        send(TB, 32'hFFFF_FFFC, 32'h0020_8063, 32'hFE20_8EE3, 0, 1, 1);
        send(TU, 32'h1234_5000, 32'h0000_0137, 32'h1234_5137, 0, 1, 1);
        send(TJ, 32'd8,         32'h0000_00EF, 32'h0080_00EF, 0, 1, 1);
        send(TJ, 32'hFFFF_FFF8, 32'h0000_00EF, 32'hFF9F_F0EF, 0, 1, 1);
        drain();
        chk("enc_after_valid", enc_count, 7);
        chk("errc_after_valid", err_count, 0);
        send(TI, 32'h800,       32'h0000_0013, 32'h0000_0013, 1, 1, 1);
        send(TB, 32'd3,         32'h0020_8063, 32'h0020_8063, 1, 1, 1);
        send(TU, 32'h1234_5001, 32'h0000_0137, 32'h0000_0137, 1, 1, 1);
        drain();
        chk("errc_three", err_count, 3);
        chk("enc_ten", enc_count, 10);
        send(TI, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 0, 1, 1);
        send(3'd7, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 0, 1, 1);
        send(TJ, 32'h0010_0000, 32'h0000_00EF, 32'h0000_00EF, 1, 1, 1);
        send(TB, 32'h0000_0FFE, 32'h0000_0063, 32'h0, 0, 0, 1);
        drain();
        chk("errc_four", err_count, 4);
        chk("enc_14", enc_count, 14);
        send(TS, 32'd1, 32'h0000_0023, 32'h0000_00A3, 0, 1, 1);
        send(TI, 32'd2, 32'h0000_0013, 32'h0020_0013, 0, 1, 1);
        drain();
        chk("enc_wrap", enc_count, 0);
        rst_n = 0;
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("rst2_enc", enc_count, 0);
        out_ready = 0;
        fork
            for (int k = 0; k < 5; k++)
                send(TI, k + 1, 32'h0000_0013, ((k + 1) << 20) | 32'h13, 0, 1, 0);
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepted", q.size(), 2);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_enc", enc_count, 0);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        drain();
        chk("bp_enc5", enc_count, 5);
        out_ready = 0;
        send(TI, 32'd5, 32'h0000_0013, 32'h0050_0013, 0, 1, 0);
        send(TI, 32'd6, 32'h0000_0013, 32'h0060_0013, 0, 1, 0);
        #2 rst_n = 0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_enc", enc_count, 0);
        chk("ar_errc", err_count, 0);
        q.delete();
        @(negedge clk) rst_n = 1;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ar_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(TS, 32'hFFFF_FFFC, 32'h0081_2023, 32'hFE81_2E23, 0, 1, 1);
        drain();
        chk("ar_enc1", enc_count, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
